// File: rtl/sb_mac16.sv
// 16x16 multiply-accumulate slice: registered operands, an optional product
// pipeline register, and two 16-bit accumulators chained into one 32-bit unit.
module sb_mac16 #(
  parameter bit       A_SIGNED                 = 1'b0,
  parameter bit       B_SIGNED                 = 1'b0,
  parameter bit       PIPELINE_16x16_MULT_REG2 = 1'b0,
  parameter bit [1:0] TOPADDSUB_LOWERINPUT     = 2'b00,
  parameter bit [1:0] BOTADDSUB_LOWERINPUT     = 2'b00,
  parameter bit [1:0] TOPOUTPUT_SELECT         = 2'b00,
  parameter bit [1:0] BOTOUTPUT_SELECT         = 2'b00
) (
  input  logic        CLK,
  input  logic        IRSTTOP,
  input  logic        IRSTBOT,
  input  logic        ORSTTOP,
  input  logic        ORSTBOT,
  input  logic        CE,
  input  logic [15:0] A,
  input  logic [15:0] B,
  input  logic [15:0] C,
  input  logic [15:0] D,
  input  logic        AHOLD,
  input  logic        BHOLD,
  input  logic        CHOLD,
  input  logic        DHOLD,
  input  logic        OHOLDTOP,
  input  logic        OHOLDBOT,
  input  logic        OLOADTOP,
  input  logic        OLOADBOT,
  input  logic        ADDSUBTOP,
  input  logic        ADDSUBBOT,
  input  logic        CI,
  input  logic        ACCUMCI,
  input  logic        SIGNEXTIN,
  output logic [31:0] O,
  output logic        CO,
  output logic        ACCUMCO,
  output logic        SIGNEXTOUT
);

  logic [15:0] a_r, b_r, c_r, d_r;
  logic [15:0] acct_r, accb_r;
  logic [31:0] prod_s, p_s;
  logic [15:0] lt_s, lb_s;
  logic [16:0] top_sum_s, bot_sum_s;
  logic        cb_s;
  logic [31:0] o_s;
  logic        unused_s;

  function automatic logic [31:0] ext16(input logic [15:0] v, input logic sgn);
    ext16 = sgn ? {{16{v[15]}}, v} : {16'h0000, v};
  endfunction

  // Bit 16 of the 17-bit result is the carry (add) or the borrow (subtract).
  function automatic logic [16:0] add_sub(input logic [15:0] acc, input logic [15:0] opnd,
                                          input logic cin, input logic sub);
    if (sub) begin
      add_sub = {1'b0, acc} - {1'b0, opnd} - {16'h0000, cin};
    end else begin
      add_sub = {1'b0, acc} + {1'b0, opnd} + {16'h0000, cin};
    end
  endfunction

  function automatic logic [15:0] lower_sel(input logic [1:0] sel, input logic [15:0] reg_v,
                                            input logic [15:0] p_half);
    case (sel)
      2'b00, 2'b01: lower_sel = reg_v;
      2'b10:        lower_sel = p_half;
      2'b11:        lower_sel = 16'h0000;
      default:      lower_sel = 16'h0000;
    endcase
  endfunction

  function automatic logic [15:0] out_sel(input logic [1:0] sel, input logic [15:0] sum_v,
                                          input logic [15:0] acc_v, input logic [15:0] p_half);
    case (sel)
      2'b00:        out_sel = sum_v;
      2'b01:        out_sel = acc_v;
      2'b10, 2'b11: out_sel = p_half;
      default:      out_sel = 16'h0000;
    endcase
  endfunction

  // Top operand registers A and C
  always_ff @(posedge CLK) begin
    if (IRSTTOP) begin
      a_r <= 16'h0000;
      c_r <= 16'h0000;
    end else if (CE) begin
      if (!AHOLD) a_r <= A;
      if (!CHOLD) c_r <= C;
    end
  end

  // Bottom operand registers B and D
  always_ff @(posedge CLK) begin
    if (IRSTBOT) begin
      b_r <= 16'h0000;
      d_r <= 16'h0000;
    end else if (CE) begin
      if (!BHOLD) b_r <= B;
      if (!DHOLD) d_r <= D;
    end
  end

  // Only the low 32 bits of the extended product are kept, which is exact for 16x16.
  assign prod_s = ext16(a_r, A_SIGNED) * ext16(b_r, B_SIGNED);

  if (PIPELINE_16x16_MULT_REG2) begin : g_preg
    logic [31:0] p_r;
    // Product pipeline register, cleared with the top input stage
    always_ff @(posedge CLK) begin
      if (IRSTTOP) begin
        p_r <= 32'h0000_0000;
      end else if (CE) begin
        p_r <= prod_s;
      end
    end
    assign p_s = p_r;
  end else begin : g_pcomb
    assign p_s = prod_s;
  end

  assign lt_s      = lower_sel(TOPADDSUB_LOWERINPUT, c_r, p_s[31:16]);
  assign lb_s      = lower_sel(BOTADDSUB_LOWERINPUT, d_r, p_s[15:0]);
  assign bot_sum_s = add_sub(accb_r, lb_s, CI, ADDSUBBOT);
  assign cb_s      = bot_sum_s[16];
  assign top_sum_s = add_sub(acct_r, lt_s, cb_s, ADDSUBTOP);

  // Top accumulator: reset, then hold, then load, then accumulate
  always_ff @(posedge CLK) begin
    if (ORSTTOP) begin
      acct_r <= 16'h0000;
    end else if (!CE || OHOLDTOP) begin
      acct_r <= acct_r;
    end else if (OLOADTOP) begin
      acct_r <= c_r;
    end else begin
      acct_r <= top_sum_s[15:0];
    end
  end

  // Bottom accumulator: reset, then hold, then load, then accumulate
  always_ff @(posedge CLK) begin
    if (ORSTBOT) begin
      accb_r <= 16'h0000;
    end else if (!CE || OHOLDBOT) begin
      accb_r <= accb_r;
    end else if (OLOADBOT) begin
      accb_r <= d_r;
    end else begin
      accb_r <= bot_sum_s[15:0];
    end
  end

  // Output source select per half
  always_comb begin
    o_s = 32'h0000_0000;
    o_s[31:16] = out_sel(TOPOUTPUT_SELECT, top_sum_s[15:0], acct_r, p_s[31:16]);
    o_s[15:0]  = out_sel(BOTOUTPUT_SELECT, bot_sum_s[15:0], accb_r, p_s[15:0]);
  end

  assign O          = o_s;
  assign CO         = top_sum_s[16];
  assign ACCUMCO    = top_sum_s[16];
  assign SIGNEXTOUT = o_s[31];
  // Cascade inputs have no function in this slice.
  assign unused_s   = ^{ACCUMCI, SIGNEXTIN};

endmodule

// File: tb/tb_sb_mac16.sv
// Directed scoreboard bench for sb_mac16: three parameterisations share one
// stimulus stream; expected values are queued as stimulus is applied.
module tb_sb_mac16;

  logic        clk;
  logic        irsttop, irstbot, orsttop, orstbot, ce;
  logic [15:0] a, b, c, d;
  logic        ahold, bhold, chold, dhold;
  logic        oholdtop, oholdbot, oloadtop, oloadbot;
  logic        addsubtop, addsubbot, ci, accumci, signextin;

  logic [31:0] o_p, o_a, o_c;
  logic        co_p, co_a, co_c;
  logic        aco_p, aco_a, aco_c;
  logic        sx_p, sx_a, sx_c;

  typedef struct {
    string       tag;
    logic [31:0] val;
  } exp_t;

  exp_t sbq[$];
  int   checks   = 0;
  int   failures = 0;

  // Product view: signed A, pipelined product driven straight to O
  sb_mac16 #(
    .A_SIGNED(1'b1), .B_SIGNED(1'b0), .PIPELINE_16x16_MULT_REG2(1'b1),
    .TOPADDSUB_LOWERINPUT(2'b10), .BOTADDSUB_LOWERINPUT(2'b10),
    .TOPOUTPUT_SELECT(2'b10), .BOTOUTPUT_SELECT(2'b10)
  ) dut_p (
    .CLK(clk), .IRSTTOP(irsttop), .IRSTBOT(irstbot), .ORSTTOP(orsttop), .ORSTBOT(orstbot),
    .CE(ce), .A(a), .B(b), .C(c), .D(d),
    .AHOLD(ahold), .BHOLD(bhold), .CHOLD(chold), .DHOLD(dhold),
    .OHOLDTOP(oholdtop), .OHOLDBOT(oholdbot), .OLOADTOP(oloadtop), .OLOADBOT(oloadbot),
    .ADDSUBTOP(addsubtop), .ADDSUBBOT(addsubbot), .CI(ci), .ACCUMCI(accumci),
    .SIGNEXTIN(signextin), .O(o_p), .CO(co_p), .ACCUMCO(aco_p), .SIGNEXTOUT(sx_p)
  );

  // 32-bit accumulator of the pipelined product, accumulator registers on O
  sb_mac16 #(
    .A_SIGNED(1'b1), .B_SIGNED(1'b0), .PIPELINE_16x16_MULT_REG2(1'b1),
    .TOPADDSUB_LOWERINPUT(2'b10), .BOTADDSUB_LOWERINPUT(2'b10),
    .TOPOUTPUT_SELECT(2'b01), .BOTOUTPUT_SELECT(2'b01)
  ) dut_a (
    .CLK(clk), .IRSTTOP(irsttop), .IRSTBOT(irstbot), .ORSTTOP(orsttop), .ORSTBOT(orstbot),
    .CE(ce), .A(a), .B(b), .C(c), .D(d),
    .AHOLD(ahold), .BHOLD(bhold), .CHOLD(chold), .DHOLD(dhold),
    .OHOLDTOP(oholdtop), .OHOLDBOT(oholdbot), .OLOADTOP(oloadtop), .OLOADBOT(oloadbot),
    .ADDSUBTOP(addsubtop), .ADDSUBBOT(addsubbot), .CI(ci), .ACCUMCI(accumci),
    .SIGNEXTIN(signextin), .O(o_a), .CO(co_a), .ACCUMCO(aco_a), .SIGNEXTOUT(sx_a)
  );

  // Combinational adders on O: top adds Cr, bottom adds the unpipelined product
  sb_mac16 #(
    .A_SIGNED(1'b0), .B_SIGNED(1'b0), .PIPELINE_16x16_MULT_REG2(1'b0),
    .TOPADDSUB_LOWERINPUT(2'b00), .BOTADDSUB_LOWERINPUT(2'b10),
    .TOPOUTPUT_SELECT(2'b00), .BOTOUTPUT_SELECT(2'b00)
  ) dut_c (
    .CLK(clk), .IRSTTOP(irsttop), .IRSTBOT(irstbot), .ORSTTOP(orsttop), .ORSTBOT(orstbot),
    .CE(ce), .A(a), .B(b), .C(c), .D(d),
    .AHOLD(ahold), .BHOLD(bhold), .CHOLD(chold), .DHOLD(dhold),
    .OHOLDTOP(oholdtop), .OHOLDBOT(oholdbot), .OLOADTOP(oloadtop), .OLOADBOT(oloadbot),
    .ADDSUBTOP(addsubtop), .ADDSUBBOT(addsubbot), .CI(ci), .ACCUMCI(accumci),
    .SIGNEXTIN(signextin), .O(o_c), .CO(co_c), .ACCUMCO(aco_c), .SIGNEXTOUT(sx_c)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push(input string tag, input logic [31:0] val);
    exp_t e;
    e.tag = tag;
    e.val = val;
    sbq.push_back(e);
  endtask

  task automatic pop_check(input logic [31:0] obs);
    exp_t e;
    checks++;
    if (sbq.size() == 0) begin
      failures++;
      $error("FAIL scoreboard_empty observed=%h", obs);
    end else begin
      e = sbq.pop_front();
      assert (obs === e.val) else begin
        failures++;
        $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.val);
      end
    end
  endtask

  initial begin
    irsttop = 1'b1; irstbot = 1'b1; orsttop = 1'b1; orstbot = 1'b1; ce = 1'b1;
    a = 16'h0000; b = 16'h0000; c = 16'h0000; d = 16'h0000;
    ahold = 1'b0; bhold = 1'b0; chold = 1'b0; dhold = 1'b0;
    oholdtop = 1'b0; oholdbot = 1'b0; oloadtop = 1'b0; oloadbot = 1'b0;
    addsubtop = 1'b0; addsubbot = 1'b0; ci = 1'b1; accumci = 1'b1; signextin = 1'b1;

    // All four resets for one edge; CI=1 shows through the combinational adder only
    push("rst_acc", 32'h0000_0000);
    push("rst_prod", 32'h0000_0000);
    push("rst_comb_ci", 32'h0000_0001);
    tick();
    pop_check(o_a);
    pop_check(o_p);
    pop_check(o_c);

    // Signed x unsigned product; accumulators kept in reset
    ci = 1'b0; irsttop = 1'b0; irstbot = 1'b0;
    a = 16'hFFFD; b = 16'h0005;
    push("prod_latency", 32'h0000_0000);
    push("comb_unsigned_prod", 32'h0000_FFF1);
    tick();
    pop_check(o_p);
    pop_check(o_c);
    push("signed_prod", 32'hFFFF_FFF1);
    tick();
    pop_check(o_p);

    // Accumulate (2,3), (4,5), (-1,7)
    a = 16'h0002; b = 16'h0003;
    tick();
    a = 16'h0004; b = 16'h0005;
    tick();
    orsttop = 1'b0; orstbot = 1'b0;
    a = 16'hFFFF; b = 16'h0007;
    push("accum_6", 32'h0000_0006);
    tick();
    pop_check(o_a);
    a = 16'h0000; b = 16'h0000;
    push("accum_26", 32'h0000_001A);
    tick();
    pop_check(o_a);
    push("accum_19", 32'h0000_0013);
    tick();
    pop_check(o_a);

    // Load from Cr/Dr
    c = 16'h1234; d = 16'h5678;
    tick();
    oloadtop = 1'b1; oloadbot = 1'b1;
    push("load_acc", 32'h1234_5678);
    push("load_comb", 32'h2468_5678);
    tick();
    pop_check(o_a);
    pop_check(o_c);

    // Hold beats load, with a nonzero product present
    oholdtop = 1'b1; oholdbot = 1'b1;
    a = 16'h0001; b = 16'h0001;
    tick(3);
    push("hold_acc", 32'h1234_5678);
    push("hold_comb", 32'h2468_5679);
    pop_check(o_a);
    pop_check(o_c);

    // Carry from bottom into top half
    c = 16'h0000; d = 16'hFFFF;
    tick();
    oholdtop = 1'b0; oholdbot = 1'b0;
    push("preload_ffff", 32'h0000_FFFF);
    tick();
    pop_check(o_a);
    oloadtop = 1'b0; oloadbot = 1'b0;
    push("carry_chain", 32'h0001_0000);
    tick();
    pop_check(o_a);
    push("carry_co", 32'h0000_0000);
    pop_check({31'h0, co_a});

    // Subtract 3 from 10, then borrow through both halves
    c = 16'h0000; d = 16'h000A;
    tick();
    oloadtop = 1'b1; oloadbot = 1'b1;
    a = 16'h0003; b = 16'h0001;
    tick(2);
    push("sub_preload", 32'h0000_000A);
    pop_check(o_a);
    oloadtop = 1'b0; oloadbot = 1'b0;
    addsubtop = 1'b1; addsubbot = 1'b1;
    push("sub_7", 32'h0000_0007);
    tick();
    pop_check(o_a);
    tick(2);
    push("borrow_co", 32'h0000_0001);
    pop_check({31'h0, co_a});
    push("sub_wrap", 32'hFFFF_FFFE);
    tick();
    pop_check(o_a);
    push("signext_out", 32'h0000_0001);
    pop_check({31'h0, sx_a});

    // CE low freezes everything, reset still acts
    ce = 1'b0;
    tick(3);
    push("ce_freeze", 32'hFFFF_FFFE);
    pop_check(o_a);
    orstbot = 1'b1;
    push("ce_low_orstbot", 32'hFFFF_0000);
    tick();
    pop_check(o_a);

    // Top reset mid-accumulation leaves bottom running
    orstbot = 1'b0; ce = 1'b1;
    addsubtop = 1'b0; addsubbot = 1'b0;
    orsttop = 1'b1;
    push("orsttop_only", 32'h0000_0003);
    tick();
    pop_check(o_a);
    orsttop = 1'b0;

    // IRSTBOT clears Br; BHOLD keeps it cleared
    irstbot = 1'b1;
    tick();
    irstbot = 1'b0; bhold = 1'b1;
    tick(2);
    push("irstbot_acc", 32'h0000_0009);
    push("irstbot_prod", 32'h0000_0000);
    pop_check(o_a);
    pop_check(o_p);

    // AHOLD keeps Ar while Br updates
    bhold = 1'b0; b = 16'h0002;
    ahold = 1'b1; a = 16'h0007;
    tick(2);
    push("ahold_prod", 32'h0000_0006);
    pop_check(o_p);
    ahold = 1'b0;
    tick(2);
    push("ahold_release", 32'h0000_000E);
    pop_check(o_p);

    if (sbq.size() != 0) begin
      checks++;
      failures++;
      $error("FAIL scoreboard_leftover observed=%0d expected=0", sbq.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
